// File: rtl/mul_req_sched.sv
// Request scheduler for a sequential 32x32 multiplier: FIFO-buffered launch, done wait, watchdog; MUL_ZERO_BYPASS_EN answers zero operands without launching.
// Latency: pop to start pulse 1 cycle, done sampled from the 2nd wait cycle, response 1 cycle after done (or after TIMEOUT wait cycles).
// Backpressure: req_ready drops when the FIFO is full; a held response (rsp_ready low) stalls all further launches.
module mul_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         empty
);
    // Generic registered FIFO; pop_dat shows the head combinationally from storage.
    // Latency: a pushed entry is visible one cycle after the push edge (no fall-through).
    // Backpressure: push ignored when full, even with a simultaneous pop.
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

module mul_req_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mul_in_valid,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    input  logic [63:0]      mul_p,
    input  logic             mul_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_p,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      y;
        logic [31:0]      x;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    req_t             push_dat;
    req_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             head_zero;
    state_t           state;
    logic [WD_W-1:0]  wdog;
    logic [TAG_W-1:0] cur_tag;

    assign push_dat  = {req_tag, req_y, req_x};
    assign req_ready = !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign busy      = (state != S_IDLE) || !fifo_empty;

`ifdef MUL_ZERO_BYPASS_EN
    assign head_zero = (head.x == 32'd0) || (head.y == 32'd0);
`else
    assign head_zero = 1'b0;
`endif

    mul_req_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (req_valid),
        .push_dat (push_dat),
        .full     (fifo_full),
        .pop_vld  (pop),
        .pop_dat  (head),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wdog         <= '0;
            cur_tag      <= '0;
            mul_in_valid <= 1'b0;
            mul_x        <= '0;
            mul_y        <= '0;
            rsp_valid    <= 1'b0;
            rsp_p        <= '0;
            rsp_tag      <= '0;
            rsp_err      <= 1'b0;
        end else begin
            mul_in_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        mul_x   <= head.x;
                        mul_y   <= head.y;
                        cur_tag <= head.tag;
                        if (head_zero) begin
                            rsp_valid <= 1'b1;
                            rsp_p     <= '0;
                            rsp_err   <= 1'b0;
                            rsp_tag   <= head.tag;
                            state     <= S_RESP;
                        end else begin
                            mul_in_valid <= 1'b1;
                            state        <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // wdog==0 marks the first wait cycle, where a stale done level is ignored
                    if ((wdog != '0) && mul_out_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_p     <= mul_p;
                        rsp_err   <= 1'b0;
                        rsp_tag   <= cur_tag;
                        state     <= S_RESP;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_p     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_tag   <= cur_tag;
                        state     <= S_RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_req_sched.sv
// Bench for mul_req_sched: multiplier model, request scoreboard and per-cycle response checker.
module tb_mul_req_sched;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int TAG_W   = 4;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x;
    logic [31:0]      req_y;
    logic [TAG_W-1:0] req_tag;
    logic             mul_in_valid;
    logic [31:0]      mul_x;
    logic [31:0]      mul_y;
    logic [63:0]      mul_p;
    logic             mul_out_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_p;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    mul_req_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_tag       (req_tag),
        .mul_in_valid  (mul_in_valid),
        .mul_x         (mul_x),
        .mul_y         (mul_y),
        .mul_p         (mul_p),
        .mul_out_valid (mul_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_p         (rsp_p),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      p;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    bit   hq[$];
    logic [63:0]      log_p[$];
    logic [TAG_W-1:0] log_tag[$];
    logic             log_err[$];

    bit   hang_next  = 0;
    bit   stale_mode = 0;
    int   lat        = 1;
    int   launches   = 0;
    bit   saw_full   = 0;
    int   last_lat   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] a;
        logic [63:0] b;
        a = {{32{x[31]}}, x};
        b = {32'd0, y};
        return a * b;
    endfunction

    function automatic bit is_bypass(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_ZERO_BYPASS_EN
        return (x == 32'd0) || (y == 32'd0);
`else
        return (x != x) && (y != y);
`endif
    endfunction

    // Accepted requests feed the scoreboard in arrival order.
    always @(negedge clk) begin
        if (!rst) begin
            if (!req_ready) saw_full = 1;
            if (req_valid && req_ready) begin
                exp_t e;
                e.tag = req_tag;
                e.err = hang_next && !is_bypass(req_x, req_y);
                e.p   = e.err ? 64'd0 : ref_prod(req_x, req_y);
                expq.push_back(e);
                if (!is_bypass(req_x, req_y)) hq.push_back(hang_next);
            end
        end
    end

    // Multiplier model: level done after lat cycles, optionally keeping an old done level briefly.
    logic [63:0] prod_next;
    int  cnt       = 0;
    bit  pending   = 0;
    int  stale_cnt = 0;
    bit  miv_prev  = 0;
    always @(negedge clk) begin
        if (rst) begin
            mul_out_valid = 1'b0;
            mul_p         = 64'd0;
            pending       = 0;
            stale_cnt     = 0;
            miv_prev      = 0;
        end else begin
            if (stale_cnt > 0) begin
                stale_cnt--;
                if (stale_cnt == 0) mul_out_valid = 1'b0;
            end
            if (pending) begin
                cnt--;
                if (cnt <= 0) begin
                    mul_p         = prod_next;
                    mul_out_valid = 1'b1;
                    pending       = 0;
                end
            end
            if (mul_in_valid) begin
                bit h;
                launches++;
                chk("start_pulse_width", {63'd0, miv_prev}, 64'd0);
                h = (hq.size() > 0) ? hq.pop_front() : 1'b0;
                prod_next = ref_prod(mul_x, mul_y);
                if (stale_mode && mul_out_valid) stale_cnt = 2;
                else mul_out_valid = 1'b0;
                if (!h) begin
                    pending = 1;
                    cnt     = lat;
                end
            end
            miv_prev = mul_in_valid;
        end
    end

    // Response checker: order, content, hold stability and watchdog latency.
    bit               prev_hold  = 0;
    bit               prev_valid = 0;
    logic [63:0]      hold_p;
    logic [TAG_W-1:0] hold_tag;
    logic             hold_err;
    int               since = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold  = 0;
            prev_valid = 0;
        end else begin
            if (mul_in_valid) since = 0;
            else since++;
            if (rsp_valid && !prev_valid) begin
                last_lat = since;
                if (expq.size() > 0 && expq[0].err) chk("timeout_latency", since, TIMEOUT + 1);
            end
            if (prev_hold) begin
                chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
                chk("hold_p", rsp_p, hold_p);
                chk("hold_tag", rsp_tag, hold_tag);
                chk("hold_err", rsp_err, hold_err);
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("rsp_p", rsp_p, e.p);
                    chk("rsp_tag", rsp_tag, e.tag);
                    chk("rsp_err", rsp_err, e.err);
                    log_p.push_back(rsp_p);
                    log_tag.push_back(rsp_tag);
                    log_err.push_back(rsp_err);
                end
            end
            prev_hold  = rsp_valid && !rsp_ready;
            prev_valid = rsp_valid;
            hold_p     = rsp_p;
            hold_tag   = rsp_tag;
            hold_err   = rsp_err;
        end
    end

    task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] tag);
        int n = 0;
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("push_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        req_valid = 1'b0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_p.delete();
        log_tag.delete();
        log_err.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int l0;
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_mul_in_valid", {63'd0, mul_in_valid}, 64'd0);
        chk("reset_mul_x", {32'd0, mul_x}, 64'd0);
        chk("reset_mul_y", {32'd0, mul_y}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_p", rsp_p, 64'd0);
        chk("reset_rsp_tag", {60'd0, rsp_tag}, 64'd0);
        chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);

        // Single signed request at the fastest multiplier response.
        @(posedge clk); #1;
        clear_log();
        lat = 1;
        push(32'hFFFF_FFFF, 32'h0000_0002, 4'd3);
        drain(200);
        chk("t1_launches", launches, 1);
        chk("t1_p_literal", log_p[0], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t1_tag_literal", {60'd0, log_tag[0]}, 64'd3);
        chk("t1_min_latency", last_lat, 3);

        // Five back-to-back requests overflow a 4-deep FIFO while the first runs.
        clear_log();
        lat      = 4;
        saw_full = 0;
        push(32'd7,         32'h8000_0000, 4'd0);
        push(32'd3,         32'd5,         4'd1);
        push(32'hFFFF_FFFE, 32'd10,        4'd2);
        push(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd3);
        push(32'h8000_0000, 32'd3,         4'd4);
        drain(400);
        chk("t2_saw_full", {63'd0, saw_full}, 64'd1);
        chk("t2_count", log_p.size(), 5);
        chk("t2_p0_literal", log_p[0], 64'h0000_0003_8000_0000);
        chk("t2_p2_literal", log_p[2], 64'hFFFF_FFFF_FFFF_FFEC);
        chk("t2_tag4_literal", {60'd0, log_tag[4]}, 64'd4);

        // Stale done level from the previous op is held into the first wait cycle.
        clear_log();
        stale_mode = 1;
        lat        = 3;
        push(32'd5, 32'd6, 4'd1);
        push(32'd9, 32'd9, 4'd2);
        drain(200);
        stale_mode = 0;
        chk("t3_p0_literal", log_p[0], 64'd30);
        chk("t3_p1_literal", log_p[1], 64'd81);

        // Multiplier never answers: watchdog error, then normal service resumes.
        clear_log();
        lat       = 2;
        hang_next = 1;
        push(32'd1, 32'd1, 4'd5);
        hang_next = 0;
        push(32'd2, 32'd3, 4'd6);
        drain(400);
        chk("t4_err_literal", {63'd0, log_err[0]}, 64'd1);
        chk("t4_p0_literal", log_p[0], 64'd0);
        chk("t4_p1_literal", log_p[1], 64'd6);
        chk("t4_err1_literal", {63'd0, log_err[1]}, 64'd0);

        // Consumer stalls for 10 cycles with another request queued.
        rsp_ready = 1'b0;
        push(32'd4, 32'd4, 4'd7);
        push(32'd5, 32'd5, 4'd8);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_rsp_seen", {63'd0, rsp_valid}, 64'd1);
        l0 = launches;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_launch_while_held", launches, l0);
        chk("t5_still_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t5_held_tag", {60'd0, rsp_tag}, 64'd7);
        rsp_ready = 1'b1;
        drain(200);

        // Reset while waiting on the multiplier drops everything.
        hang_next = 1;
        l0 = launches;
        push(32'd3, 32'd3, 4'd10);
        req_valid = 1'b0;
        n = 0;
        while (launches == l0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_launched", launches, l0 + 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_mul_in_valid", {63'd0, mul_in_valid}, 64'd0);
        chk("t6_rst_mul_x", {32'd0, mul_x}, 64'd0);
        chk("t6_rst_mul_y", {32'd0, mul_y}, 64'd0);
        chk("t6_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t6_rst_rsp_p", rsp_p, 64'd0);
        chk("t6_rst_rsp_tag", {60'd0, rsp_tag}, 64'd0);
        chk("t6_rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        expq.delete();
        hq.delete();
        hang_next = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t6_req_ready", {63'd0, req_ready}, 64'd1);
        chk("t6_busy_after", {63'd0, busy}, 64'd0);
        l0 = launches;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("t6_no_launch", launches, l0);

        // Zero operand: launched normally, or answered directly when bypass is built in.
        clear_log();
        l0 = launches;
        push(32'd0, 32'd123, 4'd9);
        drain(200);
        chk("t7_p_literal", log_p[0], 64'd0);
`ifdef MUL_ZERO_BYPASS_EN
        chk("t7_launches", launches, l0);
        chk("t7_mul_x_updated", {32'd0, mul_x}, 64'd0);
        chk("t7_mul_y_updated", {32'd0, mul_y}, 64'd123);
`else
        chk("t7_launches", launches, l0 + 1);
`endif

        chk("final_scoreboard_empty", expq.size(), 0);
        chk("final_idle", {63'd0, busy}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_req_sched.md
Name: mul_req_sched

Overview:
- Upstream request scheduler for the sequential 32-bit multiplier (signed x, unsigned y, 64-bit product).
- Accepts operand pairs over a valid/ready interface into a small FIFO and launches them one at a time with a single-cycle start pulse.
- Holds the multiplier operands stable while the multiplier runs, waits for its done level, and returns the tagged 64-bit product to a valid/ready consumer.
- A watchdog flags an operation that never completes.

Parameters:
- DEPTH, 4, operand FIFO entries (power of 2, >=2).
- TIMEOUT, 64, max WAIT cycles before the error response (>=40).
- TAG_W, 4, request tag width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_x  in  32  signed multiplicand.
- req_y  in  32  unsigned multiplier.
- req_tag  in  TAG_W  request tag, returned unchanged.
- mul_in_valid  out  1  one-cycle start pulse to the multiplier.
- mul_x  out  32  operand x to the multiplier, registered.
- mul_y  out  32  operand y to the multiplier, registered.
- mul_p  in  64  multiplier product.
- mul_out_valid  in  1  multiplier done; level, cleared by the multiplier after mul_in_valid.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_p  out  64  product (0 on error).
- rsp_tag  out  TAG_W  tag of the response.
- rsp_err  out  1  watchdog expired.
- busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; state IDLE; watchdog count 0.
  - req_ready=1 once rst deasserts; all other outputs 0 (mul_x, mul_y, rsp_p, rsp_tag included).
  - Reset mid-operation abandons the in-flight operation and queued requests; no response is produced for them.
- FIFO:
  - A push occurs on an edge with req_valid & req_ready.
  - req_ready = !full. A push is refused when full even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH. A simultaneous push and pop when not full keeps the count unchanged.
  - An entry pushed into an empty FIFO is poppable on the next cycle (no fall-through).
- States: IDLE, LAUNCH, WAIT, RESP.
  - IDLE: if FIFO not empty, pop the head into mul_x / mul_y / tag registers and go to LAUNCH.
  - LAUNCH: mul_in_valid=1 for exactly this cycle; go to WAIT; clear the watchdog.
  - WAIT:
    - Watchdog increments each cycle.
    - mul_out_valid is ignored in the first WAIT cycle (blanking for a stale done level).
    - From the second WAIT cycle on, mul_out_valid=1 captures rsp_p=mul_p, rsp_err=0, and moves to RESP.
    - If the watchdog reaches TIMEOUT first: rsp_p=0, rsp_err=1, go to RESP.
    - If done and timeout coincide, done wins.
  - RESP: rsp_valid=1 with rsp_p / rsp_tag / rsp_err stable until the edge where rsp_ready=1; then go to IDLE. rsp_ready may be tied high.
- mul_x and mul_y hold their value from the pop until the next pop.
- Minimum launch-to-launch spacing: IDLE→LAUNCH→WAIT(≥2)→RESP→IDLE.
- Responses return in request order; exactly one response per accepted request.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: on the IDLE pop, if x==0 or y==0, go directly to RESP with rsp_p=0 and rsp_err=0. No mul_in_valid pulse is issued; mul_x and mul_y are still updated.
- Not defined: every request goes through LAUNCH/WAIT.

Test Plan:
- Single request x=32'hFFFF_FFFF (-1), y=32'h0000_0002, tag 3; the multiplier model returns 64'hFFFF_FFFF_FFFF_FFFE → exactly one mul_in_valid pulse, then rsp_valid with rsp_p=64'hFFFF_FFFF_FFFF_FFFE, rsp_tag=3, rsp_err=0.
- Push 5 requests back-to-back with DEPTH=4 while the first is executing → req_ready drops at full; all 5 responses arrive in order with tags 0..4 and correct products (x=7, y=32'h8000_0000 → 64'h0000_0003_8000_0000).
- Model holds mul_out_valid=1 from the previous op during the launch cycle and the first WAIT cycle → no premature capture; the capture uses the new product.
- Model never asserts done → rsp_err=1 and rsp_p=0 after TIMEOUT WAIT cycles; the next request completes normally.
- rsp_ready held low 10 cycles → rsp_valid/rsp_p/rsp_tag stable and no new mul_in_valid; then accepted. Separately, assert rst during WAIT → all outputs 0, FIFO empty, no response.
- With MUL_ZERO_BYPASS_EN, x=0, y=123 → rsp_p=0 with no mul_in_valid pulse. Without the macro, the same request produces a pulse and rsp_p=0 from the model.
